// File: rtl/fma16_scheduler.sv
// fma16_scheduler
// ---------------------------------------------------------------------------
// Round-robin scheduler that shares one combinational fma16 datapath between
// NREQ requesters. An operation is accepted in IDLE, is held on the fma_*
// registers for one ISSUE cycle while the datapath settles, and its result is
// captured at the ISSUE->RESP edge. The result is then presented to the
// granted requester until that requester completes the response handshake.
//
// Parameters:
//   NREQ            number of requesters (2..8)
//
// Ports:
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   req_valid/ready per-requester request handshake (ready is one-hot)
//   req_x/y/z       per-requester binary16 operands, slice i = [16*i +: 16]
//   req_ctl         per-requester {mul, add, negp, negz, roundmode[1:0]}
//   resp_valid      one-hot response valid to the granted requester
//   resp_ready      per-requester response accept
//   resp_result     captured datapath result (shared)
//   resp_flags      captured {invalid, overflow, underflow, inexact}
//   fma_*           registered operands/control driven to the datapath
//   fma_result      combinational datapath result
//   fma_flags       combinational datapath flags
//   busy            high whenever the FSM is not in IDLE
//   flags_sticky    OR of all returned flags since reset or last clear
//   flags_clr       synchronous clear of flags_sticky
//
// Build option:
//   FMA16_STICKY_FLAGS_EN  when defined, flags_sticky is a real register;
//                          otherwise it is tied to zero and flags_clr is
//                          ignored.
// ---------------------------------------------------------------------------
module fma16_scheduler #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  input  logic [NREQ*16-1:0] req_z,
  input  logic [NREQ*6-1:0] req_ctl,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [15:0]       resp_result,
  output logic [3:0]        resp_flags,
  output logic [15:0]       fma_x,
  output logic [15:0]       fma_y,
  output logic [15:0]       fma_z,
  output logic              fma_mul,
  output logic              fma_add,
  output logic              fma_negp,
  output logic              fma_negz,
  output logic [1:0]        fma_roundmode,
  input  logic [15:0]       fma_result,
  input  logic [3:0]        fma_flags,
  output logic              busy,
  output logic [3:0]        flags_sticky,
  input  logic              flags_clr
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   gnt_reg;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  logic [NREQ-1:0] grant_onehot;
  logic [NREQ-1:0] gnt_onehot;

  logic [15:0]     fma_x_reg;
  logic [15:0]     fma_y_reg;
  logic [15:0]     fma_z_reg;
  logic [5:0]      fma_ctl_reg;
  logic [15:0]     resp_result_reg;
  logic [3:0]      resp_flags_reg;
  logic [NREQ-1:0] resp_valid_reg;
  logic            busy_reg;

  // Per-requester views of the flattened operand buses.
  logic [15:0] x_slice   [NREQ];
  logic [15:0] y_slice   [NREQ];
  logic [15:0] z_slice   [NREQ];
  logic [5:0]  ctl_slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign x_slice[gi]   = req_x[16*gi +: 16];
      assign y_slice[gi]   = req_y[16*gi +: 16];
      assign z_slice[gi]   = req_z[16*gi +: 16];
      assign ctl_slice[gi] = req_ctl[6*gi +: 6];
    end
  endgenerate

  // Round-robin search starting at ptr_reg. Scanning from the farthest
  // offset down to zero leaves the nearest valid requester as the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_reg) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
  assign gnt_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << gnt_reg;

  // Gated by reset_n so no request can look accepted while reset is held.
  assign req_ready = (reset_n && (state_reg == IDLE) && grant_found) ?
                     grant_onehot : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      gnt_reg         <= '0;
      fma_x_reg       <= '0;
      fma_y_reg       <= '0;
      fma_z_reg       <= '0;
      fma_ctl_reg     <= '0;
      resp_result_reg <= '0;
      resp_flags_reg  <= '0;
      resp_valid_reg  <= '0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // grant_found implies req_valid and req_ready of the winner.
          if (grant_found) begin
            fma_x_reg   <= x_slice[grant_idx];
            fma_y_reg   <= y_slice[grant_idx];
            fma_z_reg   <= z_slice[grant_idx];
            fma_ctl_reg <= ctl_slice[grant_idx];
            gnt_reg     <= grant_idx;
            busy_reg    <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          resp_result_reg <= fma_result;
          resp_flags_reg  <= fma_flags;
          resp_valid_reg  <= gnt_onehot;
          state_reg       <= RESP;
        end
        RESP: begin
          if (resp_ready[gnt_reg]) begin
            resp_valid_reg <= '0;
            busy_reg       <= 1'b0;
            ptr_reg        <= (gnt_reg == PW'(NREQ - 1)) ? '0 : gnt_reg + 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          resp_valid_reg <= '0;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign fma_x         = fma_x_reg;
  assign fma_y         = fma_y_reg;
  assign fma_z         = fma_z_reg;
  assign fma_mul       = fma_ctl_reg[5];
  assign fma_add       = fma_ctl_reg[4];
  assign fma_negp      = fma_ctl_reg[3];
  assign fma_negz      = fma_ctl_reg[2];
  assign fma_roundmode = fma_ctl_reg[1:0];
  assign resp_result   = resp_result_reg;
  assign resp_flags    = resp_flags_reg;
  assign resp_valid    = resp_valid_reg;
  assign busy          = busy_reg;

`ifdef FMA16_STICKY_FLAGS_EN
  logic [3:0] sticky_reg;
  logic       capture;

  assign capture = (state_reg == ISSUE);

  // Clear is applied before the OR so a clear coinciding with a capture
  // leaves exactly that operation's flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_reg <= 4'b0000;
    end else begin
      sticky_reg <= (flags_clr ? 4'b0000 : sticky_reg) |
                    (capture ? fma_flags : 4'b0000);
    end
  end

  assign flags_sticky = sticky_reg;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign flags_sticky     = 4'b0000;
`endif

endmodule

// File: tb/tb_fma16_scheduler.sv
// Directed testbench for fma16_scheduler (NREQ = 2). A small lookup-table
// stand-in for the fma16 datapath returns hand-computed results for the
// operand sets used below.
module tb_fma16_scheduler;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_x, req_y, req_z;
  logic [11:0] req_ctl;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_result;
  logic [3:0]  resp_flags;
  logic [15:0] fma_x, fma_y, fma_z;
  logic        fma_mul, fma_add, fma_negp, fma_negz;
  logic [1:0]  fma_roundmode;
  logic [15:0] fma_result;
  logic [3:0]  fma_flags;
  logic        busy;
  logic [3:0]  flags_sticky;
  logic        flags_clr;

  int checks = 0;
  int errors = 0;

  fma16_scheduler #(.NREQ(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctl(req_ctl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .busy(busy), .flags_sticky(flags_sticky), .flags_clr(flags_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: hand-computed binary16 results.
  always_comb begin
    fma_result = 16'hDEAD;
    fma_flags  = 4'b0001;
    case ({fma_x, fma_y, fma_z})
      {16'h3C00, 16'h4000, 16'h3C00}: begin fma_result = 16'h4200; fma_flags = 4'b0000; end // 1*2+1 = 3
      {16'h4000, 16'h4000, 16'h0000}: begin fma_result = 16'h4400; fma_flags = 4'b0000; end // 2*2+0 = 4
      {16'h0000, 16'h7C00, 16'h0000}: begin fma_result = 16'h7E00; fma_flags = 4'b1000; end // 0*inf = NaN
      {16'h3C00, 16'h3C00, 16'h0000}: begin fma_result = 16'h3C00; fma_flags = 4'b0000; end // 1*1+0 = 1
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [1:0] eg;
  logic [3:0] exp_sticky;

  initial begin
`ifdef FMA16_STICKY_FLAGS_EN
    exp_sticky = 4'b1000;
`else
    exp_sticky = 4'b0000;
`endif
    reset_n    = 1'b0;
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    flags_clr  = 1'b0;
    req_x   = {16'h4000, 16'h3C00};
    req_y   = {16'h4000, 16'h4000};
    req_z   = {16'h0000, 16'h3C00};
    req_ctl = {6'b110011, 6'b110000};

    // Reset state, with r0 already requesting.
    step(); step();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_fma_x", fma_x, 16'h0000);
    check("rst_fma_ctl", {fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode}, 6'b000000);
    check("rst_resp_result", resp_result, 16'h0000);
    check("rst_resp_flags", resp_flags, 4'b0000);
    check("rst_sticky", flags_sticky, 4'b0000);

    // Single operation on r0: 1*2+1.
    reset_n = 1'b1;
    #1;
    $display("txn single r0 x=3C00 y=4000 z=3C00");
    check("single_ready", req_ready, 2'b01);
    check("single_idle_busy", busy, 1'b0);
    step();  // accepted at edge N -> ISSUE
    check("single_issue_busy", busy, 1'b1);
    check("single_issue_ready", req_ready, 2'b00);
    check("single_issue_rvalid", resp_valid, 2'b00);
    check("single_fma_x", fma_x, 16'h3C00);
    check("single_fma_y", fma_y, 16'h4000);
    check("single_fma_z", fma_z, 16'h3C00);
    check("single_fma_ctl", {fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode}, 6'b110000);
    req_valid = 2'b00;
    step();  // N+1 -> RESP
    check("single_rvalid", resp_valid, 2'b01);
    check("single_result", resp_result, 16'h4200);
    check("single_flags", resp_flags, 4'b0000);
    resp_ready = 2'b01;
    step();  // N+2 -> IDLE
    check("single_done_rvalid", resp_valid, 2'b00);
    check("single_done_busy", busy, 1'b0);
    resp_ready = 2'b00;

    // Simultaneous requests from reset: expect r0, r1, r0, r1.
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      $display("txn rr op=%0d expected grant=%b", i, eg);
      check("rr_ready", req_ready, eg);
      step();
      check("rr_issue_ready", req_ready, 2'b00);
      check("rr_roundmode", fma_roundmode, (i % 2 == 0) ? 2'b00 : 2'b11);
      step();
      check("rr_rvalid", resp_valid, eg);
      check("rr_result", resp_result, (i % 2 == 0) ? 16'h4200 : 16'h4400);
      step();
    end
    req_valid = 2'b00;

    // Backpressure: r0 granted (pointer back at 0), response held 5 cycles.
    resp_ready = 2'b00;
    req_valid  = 2'b11;
    $display("txn backpressure r0");
    step();  // ISSUE
    step();  // RESP
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", resp_valid, 2'b01);
      check("bp_result", resp_result, 16'h4200);
      check("bp_ready", req_ready, 2'b00);
      check("bp_busy", busy, 1'b1);
      step();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b01;
    step();
    check("bp_done_rvalid", resp_valid, 2'b00);
    check("bp_done_busy", busy, 1'b0);
    resp_ready = 2'b00;

    // 0 * inf: invalid flag, sticky depends on build.
    req_x[15:0] = 16'h0000; req_y[15:0] = 16'h7C00; req_z[15:0] = 16'h0000;
    req_valid = 2'b01;
    $display("txn nan r0 x=0000 y=7C00 z=0000");
    step();
    req_valid = 2'b00;
    step();
    check("nan_result", resp_result, 16'h7E00);
    check("nan_flags", resp_flags, 4'b1000);
    check("nan_sticky", flags_sticky, exp_sticky);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    check("nan_sticky_hold", flags_sticky, exp_sticky);

    // Clear coinciding with the capture of a clean 1*1+0 operation.
    req_x[15:0] = 16'h3C00; req_y[15:0] = 16'h3C00; req_z[15:0] = 16'h0000;
    req_valid = 2'b01;
    $display("txn clear-on-capture r0 x=3C00 y=3C00 z=0000");
    step();  // ISSUE
    check("clr_pre_sticky", flags_sticky, exp_sticky);
    flags_clr = 1'b1;
    req_valid = 2'b00;
    step();  // RESP, clear applied on capture edge
    flags_clr = 1'b0;
    check("clr_sticky", flags_sticky, 4'b0000);
    check("clr_result", resp_result, 16'h3C00);
    check("clr_flags", resp_flags, 4'b0000);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;

    // Reset during ISSUE; pointer is at 1 before the reset.
    req_x[15:0] = 16'h3C00; req_y[15:0] = 16'h4000; req_z[15:0] = 16'h3C00;
    req_valid = 2'b01;
    $display("txn reset mid-op r0");
    step();  // ISSUE
    check("mid_issue_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rvalid", resp_valid, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 2'b00);
    check("mid_rst_fma_x", fma_x, 16'h0000);
    req_valid = 2'b11;
    step();
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 2'b01);
    check("post_rst_rvalid", resp_valid, 2'b00);
    step();  // ISSUE
    req_valid = 2'b00;
    check("post_rst_fma_x", fma_x, 16'h3C00);
    check("post_rst_issue_rvalid", resp_valid, 2'b00);
    step();  // RESP
    check("post_rst_rvalid2", resp_valid, 2'b01);
    check("post_rst_result", resp_result, 16'h4200);
    resp_ready = 2'b01;
    step();
    check("post_rst_done_busy", busy, 1'b0);
    resp_ready = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fma16_scheduler.md
# fma16_scheduler

Round-robin scheduler that shares one combinational `fma16` datapath between `NREQ` requesters. Each requester submits a complete FMA operation: operands, control bits and rounding mode. The scheduler grants one requester and registers that requester's operation onto the datapath inputs. It captures the datapath's result and flags, then returns them to the granted requester over a valid/ready response channel. It also keeps an optional sticky accumulation of exception flags for the control/status logic. It sits between the requesting execution agents and the single `fma16` instance, which includes the rounding and special-case logic.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters; legal range 2..8.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, NREQ: requester i has an operation pending; held until accepted.
- `req_ready`, out, NREQ: one-hot accept; operation i is taken on the cycle where both `req_valid[i]` and `req_ready[i]` are 1.
- `req_x`, `req_y`, `req_z`, in, NREQ*16 each: binary16 operands; slice i is `[16*i +: 16]`.
- `req_ctl`, in, NREQ*6: per-requester control `{mul, add, negp, negz, roundmode[1:0]}`; slice i is `[6*i +: 6]`.
- `resp_valid`, out, NREQ: one-hot; the result for requester i is available.
- `resp_ready`, in, NREQ: requester i accepts its response.
- `resp_result`, out, 16: result shared by all requesters; qualified by `resp_valid`.
- `resp_flags`, out, 4: `{invalid, overflow, underflow, inexact}`.
- `fma_x`, `fma_y`, `fma_z`, out, 16 each: registered operands to the datapath.
- `fma_mul`, `fma_add`, `fma_negp`, `fma_negz`, out, 1 each: registered datapath control.
- `fma_roundmode`, out, 2: registered rounding mode.
- `fma_result`, in, 16: combinational datapath result.
- `fma_flags`, in, 4: combinational datapath flags.
- `busy`, out, 1: 1 in any state other than IDLE.
- `flags_sticky`, out, 4: OR of all returned flags since reset or the last clear.
- `flags_clr`, in, 1: synchronous clear of `flags_sticky`.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant `g` is the first index with `req_valid` set, searching upward from pointer `ptr` and wrapping at NREQ-1 → 0.
  - `req_ready[g]` is 1 combinationally, only in IDLE; all other `req_ready` bits are 0.
  - On acceptance: latch slice g into the `fma_*` registers, latch `g`, go to ISSUE.
  - With no `req_valid` bit set, stay in IDLE.
- ISSUE:
  - `fma_*` registers are stable, and the datapath settles within this cycle.
  - At the clock edge, capture `fma_result`→`resp_result` and `fma_flags`→`resp_flags`; go to RESP.
- RESP:
  - `resp_valid[g]` is 1.
  - On `resp_ready[g]`: go to IDLE and set `ptr` to g+1 mod NREQ.
  - `resp_ready` bits of non-granted requesters are ignored.
  - `resp_result` and `resp_flags` are held stable until the handshake completes.
- The `fma_*` outputs hold their last values outside ISSUE; they are not cleared.
- `req_valid` deasserted before acceptance is legal; that requester is not granted.
- `resp_ready` asserted early is legal; it is used only in RESP.
- A requester may raise `req_valid` again while its response is outstanding; it is not accepted before the next IDLE.

## Timing
- Reset values: state=IDLE, `ptr`=0, `fma_*`=0, `resp_result`=0, `resp_flags`=0, `flags_sticky`=0, all `resp_valid`=0, `busy`=0.
- While reset is asserted, `req_ready`=0.
- Latency: accepted at edge N, result captured at N+1, `resp_valid` high from N+1. Completing the response at edge N+2 returns the FSM to IDLE.
- Minimum issue interval is 3 cycles per operation; there is no overlap.
- Reset asserted mid-operation: the in-flight operation is dropped, no response is produced, and `ptr` returns to 0.
- Fairness: a continuously valid requester is granted within NREQ operations.

## Configuration
- Macro: `FMA16_STICKY_FLAGS_EN`.
- Defined:
  - `flags_sticky` |= `fma_flags` at the ISSUE→RESP edge.
  - `flags_clr` zeros `flags_sticky` at the next edge.
  - When a clear and a capture land on the same edge, the result is `flags_sticky` = `fma_flags` of that operation. The clear applies first, then the new flags are ORed in.
- Undefined:
  - `flags_sticky` is tied to 4'b0000.
  - `flags_clr` is ignored.
  - No sticky register is synthesized.

## Test plan
- Single operation on r0: x=0x3C00, y=0x4000, z=0x3C00, ctl=6'b110000, with a real `fma16` attached.
  - Required: accepted at edge N, `resp_valid`=2'b01 from N+1, `resp_result`=0x4200, `resp_flags`=4'b0000.
- Simultaneous requests: r0 and r1 valid continuously for 4 operations from reset.
  - Required: grant order r0, r1, r0, r1.
  - Required: `req_ready` is never set for both requesters, and each response goes to the matching requester.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP.
  - Required: `resp_valid` and `resp_result` stay stable, no new `req_ready`, `busy`=1.
- Sticky flags (macro defined): x=0x0000, y=0x7C00, z=0x0000, ctl=6'b110000.
  - Required: `resp_result`=0x7E00, `flags_sticky`=4'b1000.
  - Then pulse `flags_clr` on the capture edge of a 1.0×1.0+0 operation; required: `flags_sticky`=4'b0000.
- Macro undefined: repeat the sticky-flags scenario.
  - Required: `resp_flags`=4'b1000 while `flags_sticky` stays 4'b0000.
- Reset mid-operation: deassert `reset_n` while in ISSUE.
  - Required: immediately `resp_valid`=0 and `busy`=0; after release, the next grant goes to r0 and no stale response is produced.
